// File: rtl/btb_assoc_if.sv
// Fetch-lookup and execute-update bundle for btb_assoc.
// The slave modport is the BTB side; the master modport is the fetch/execute side.
interface btb_assoc_if;
    logic        flush_i;
    logic [31:0] pc_f_i;
    logic        update_en_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic [31:0] update_target_i;
    logic        ready_o;
    logic        hit_o;
    logic        taken_o;
    logic [31:0] target_o;

    modport slave (
        input  flush_i,
        input  pc_f_i,
        input  update_en_i,
        input  update_pc_i,
        input  update_taken_i,
        input  update_target_i,
        output ready_o,
        output hit_o,
        output taken_o,
        output target_o
    );

    modport master (
        output flush_i,
        output pc_f_i,
        output update_en_i,
        output update_pc_i,
        output update_taken_i,
        output update_target_i,
        input  ready_o,
        input  hit_o,
        input  taken_o,
        input  target_o
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB with a sequential clear sweep and per-set round-robin victim.
// Define BTB_ASSOC_CTR_EN to add a 2-bit saturating direction counter per entry.
module btb_assoc #(
    parameter int SET_BITS = 6,
    parameter int WAYS     = 2,
    parameter int TAG_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    btb_assoc_if.slave bus
);
    localparam int SETS = 1 << SET_BITS;
    localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SET_BITS-1:0] sweep_q, sweep_d;
    logic                run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                if (bus.flush_i) begin
                    sweep_d = '0;
                end else if (sweep_q == SET_BITS'(SETS - 1)) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + SET_BITS'(1);
                end
            end
            ST_RUN: begin
                if (bus.flush_i) begin
                    state_d = ST_INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    assign run = (state_q == ST_RUN);

    logic [SET_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;

    assign f_idx = bus.pc_f_i[SET_BITS+1:2];
    assign f_tag = bus.pc_f_i[31 -: TAG_BITS];
    assign u_idx = bus.update_pc_i[SET_BITS+1:2];
    assign u_tag = bus.update_pc_i[31 -: TAG_BITS];

    logic [WAYS-1:0]               f_valid, u_valid;
    logic [WAYS-1:0][TAG_BITS-1:0] f_tag_rd, u_tag_rd;
    logic [WAYS-1:0][31:0]         f_tgt_rd;
    logic [WAYS-1:0]               way_alloc, way_retgt;
`ifdef BTB_ASSOC_CTR_EN
    logic [WAYS-1:0][1:0]          f_ctr_rd, u_ctr_rd;
    logic [WAYS-1:0]               way_ctr_we;
    logic [WAYS-1:0][1:0]          way_ctr_wd;
`endif

    // One storage column per way; valid bits are cleared one set per INIT cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic                valid_mem [SETS];
            logic [TAG_BITS-1:0] tag_mem   [SETS];
            logic [31:0]         tgt_mem   [SETS];

            always_ff @(posedge clk) begin
                if (!run) begin
                    valid_mem[sweep_q] <= 1'b0;
                end else if (way_alloc[gi]) begin
                    valid_mem[u_idx] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (way_alloc[gi]) begin
                    tag_mem[u_idx] <= u_tag;
                end
                if (way_alloc[gi] || way_retgt[gi]) begin
                    tgt_mem[u_idx] <= bus.update_target_i;
                end
            end

            assign f_valid[gi]  = valid_mem[f_idx];
            assign f_tag_rd[gi] = tag_mem[f_idx];
            assign f_tgt_rd[gi] = tgt_mem[f_idx];
            assign u_valid[gi]  = valid_mem[u_idx];
            assign u_tag_rd[gi] = tag_mem[u_idx];

`ifdef BTB_ASSOC_CTR_EN
            logic [1:0] ctr_mem [SETS];

            always_ff @(posedge clk) begin
                if (way_ctr_we[gi]) begin
                    ctr_mem[u_idx] <= way_ctr_wd[gi];
                end
            end

            assign f_ctr_rd[gi] = ctr_mem[f_idx];
            assign u_ctr_rd[gi] = ctr_mem[u_idx];
`endif
        end
    endgenerate

    logic [VW-1:0] u_vic;
    logic          vic_adv;

    generate
        if (WAYS > 1) begin : g_vic
            logic [VW-1:0] vic_mem [SETS];

            always_ff @(posedge clk) begin
                if (!run) begin
                    vic_mem[sweep_q] <= '0;
                end else if (vic_adv) begin
                    vic_mem[u_idx] <= u_vic + VW'(1);
                end
            end

            assign u_vic = vic_mem[u_idx];
        end else begin : g_novic
            assign u_vic = '0;
        end
    endgenerate

    logic          u_hit, inv_any, upd;
    logic [VW-1:0] u_hit_way, inv_way, alloc_way;

    // Downward scans so the lowest-numbered way wins.
    always_comb begin
        u_hit     = 1'b0;
        u_hit_way = '0;
        inv_any   = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (u_valid[w] && (u_tag_rd[w] == u_tag)) begin
                u_hit     = 1'b1;
                u_hit_way = VW'(w);
            end
            if (!u_valid[w]) begin
                inv_any = 1'b1;
                inv_way = VW'(w);
            end
        end
    end

    assign upd       = run && bus.update_en_i;
    assign alloc_way = inv_any ? inv_way : u_vic;

    always_comb begin
        way_alloc = '0;
        way_retgt = '0;
        vic_adv   = 1'b0;
`ifdef BTB_ASSOC_CTR_EN
        way_ctr_we = '0;
        way_ctr_wd = '0;
`endif
        if (upd && bus.update_taken_i) begin
            if (u_hit) begin
                way_retgt[u_hit_way] = 1'b1;
`ifdef BTB_ASSOC_CTR_EN
                way_ctr_we[u_hit_way] = 1'b1;
                way_ctr_wd[u_hit_way] = (u_ctr_rd[u_hit_way] == 2'd3) ? 2'd3
                                                                      : u_ctr_rd[u_hit_way] + 2'd1;
`endif
            end else begin
                way_alloc[alloc_way] = 1'b1;
                vic_adv              = !inv_any;
`ifdef BTB_ASSOC_CTR_EN
                way_ctr_we[alloc_way] = 1'b1;
                way_ctr_wd[alloc_way] = 2'd2;
`endif
            end
        end
`ifdef BTB_ASSOC_CTR_EN
        if (upd && !bus.update_taken_i && u_hit) begin
            way_ctr_we[u_hit_way] = 1'b1;
            way_ctr_wd[u_hit_way] = (u_ctr_rd[u_hit_way] == 2'd0) ? 2'd0
                                                                  : u_ctr_rd[u_hit_way] - 2'd1;
        end
`endif
    end

    logic          f_hit;
    logic [VW-1:0] f_way;

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (f_valid[w] && (f_tag_rd[w] == f_tag)) begin
                f_hit = 1'b1;
                f_way = VW'(w);
            end
        end
    end

    assign bus.ready_o  = run;
    assign bus.hit_o    = run && f_hit;
    assign bus.target_o = (run && f_hit) ? f_tgt_rd[f_way] : 32'd0;
`ifdef BTB_ASSOC_CTR_EN
    assign bus.taken_o  = run && f_hit && f_ctr_rd[f_way][1];
`else
    assign bus.taken_o  = run && f_hit;
`endif

    // Low PC bits and the pointer strobe are deliberately partly unused in some configurations.
    logic unused_bits;
    assign unused_bits = ^{bus.pc_f_i, bus.update_pc_i, vic_adv};
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: a table-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_btb_assoc;
    localparam int SET_BITS = 6;
    localparam int WAYS     = 2;
    localparam int TAG_BITS = 12;
    localparam int SETS     = 1 << SET_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_assoc_if bus ();

    btb_assoc #(
        .SET_BITS (SET_BITS),
        .WAYS     (WAYS),
        .TAG_BITS (TAG_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: whole table cleared at once; INIT is a countdown of remaining cycles.
    bit                  m_valid [SETS][WAYS];
    logic [TAG_BITS-1:0] m_tag   [SETS][WAYS];
    logic [31:0]         m_tgt   [SETS][WAYS];
    int                  m_ctr   [SETS][WAYS];
    int                  m_vic   [SETS];
    int                  init_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_vic[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        init_left = SETS;
    endtask

    task automatic model_find(input logic [31:0] pc, output int s, output int hw);
        logic [TAG_BITS-1:0] t;
        s  = int'(pc[SET_BITS+1:2]);
        t  = pc[31 -: TAG_BITS];
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        int s, hw, w;
        model_find(pc, s, hw);
        if (tk) begin
            if (hw >= 0) begin
                m_tgt[s][hw] = tgt;
                if (m_ctr[s][hw] < 3) m_ctr[s][hw]++;
            end else begin
                w = -1;
                for (int i = 0; i < WAYS; i++) if (w < 0 && !m_valid[s][i]) w = i;
                if (w < 0) begin
                    w        = m_vic[s];
                    m_vic[s] = (m_vic[s] + 1) % WAYS;
                end
                m_valid[s][w] = 1'b1;
                m_tag[s][w]   = pc[31 -: TAG_BITS];
                m_tgt[s][w]   = tgt;
                m_ctr[s][w]   = 2;
            end
        end else if (hw >= 0 && m_ctr[s][hw] > 0) begin
            m_ctr[s][hw]--;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_clear();
            end else if (init_left > 0) begin
                if (bus.flush_i) model_clear();
                else init_left--;
            end else begin
                if (bus.update_en_i)
                    model_update(bus.update_pc_i, bus.update_taken_i, bus.update_target_i);
                if (bus.flush_i) model_clear();
            end
        end
    end

    initial begin
        bit          e_ready, e_hit, e_taken;
        logic [31:0] e_tgt;
        int          s, hw;
        forever begin
            @(negedge clk);
            e_ready = !rst && (init_left == 0);
            e_hit   = 1'b0;
            e_taken = 1'b0;
            e_tgt   = 32'd0;
            if (e_ready) begin
                model_find(bus.pc_f_i, s, hw);
                if (hw >= 0) begin
                    e_hit = 1'b1;
                    e_tgt = m_tgt[s][hw];
`ifdef BTB_ASSOC_CTR_EN
                    e_taken = (m_ctr[s][hw] >= 2);
`else
                    e_taken = 1'b1;
`endif
                end
            end
            chk("cyc_ready",  32'(bus.ready_o), 32'(e_ready));
            chk("cyc_hit",    32'(bus.hit_o),   32'(e_hit));
            chk("cyc_taken",  32'(bus.taken_o), 32'(e_taken));
            chk("cyc_target", bus.target_o,     e_tgt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.update_en_i     = 1'b1;
        bus.update_pc_i     = pc;
        bus.update_taken_i  = tk;
        bus.update_target_i = tgt;
        tick();
        bus.update_en_i = 1'b0;
        $display("[TB] update pc=%h taken=%0d target=%h ready=%0d", pc, tk, tgt, bus.ready_o);
    endtask

    task automatic look(input logic [31:0] pc);
        bus.pc_f_i = pc;
        #1;
    endtask

    initial begin
        bus.flush_i         = 1'b0;
        bus.pc_f_i          = 32'd0;
        bus.update_en_i     = 1'b0;
        bus.update_pc_i     = 32'd0;
        bus.update_taken_i  = 1'b0;
        bus.update_target_i = 32'd0;

        // Reset and initial sweep
        repeat (3) tick();
        look(32'h0000_1000);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_hit",   32'(bus.hit_o),   32'd0);
        rst = 1'b0;
        upd(32'h0070_0000, 1'b1, 32'h7777_0000);
        look(32'h0070_0000);
        chk("init_hit",    32'(bus.hit_o), 32'd0);
        chk("init_target", bus.target_o,   32'd0);
        repeat (62) @(posedge clk);
        #1;
        chk("init_ready_63", 32'(bus.ready_o), 32'd0);
        tick();
        chk("init_ready_64", 32'(bus.ready_o), 32'd1);
        look(32'h0070_0000);
        chk("init_update_dropped", 32'(bus.hit_o), 32'd0);

        // Basic allocate and lookup
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        look(32'h0000_1000);
        chk("basic_hit",    32'(bus.hit_o), 32'd1);
        chk("basic_target", bus.target_o,   32'h0000_2000);
        look(32'h0010_1000);
        chk("other_tag_miss", 32'(bus.hit_o), 32'd0);

        // Fill set 0, then round-robin eviction
        upd(32'h0010_1000, 1'b1, 32'h0000_3000);
        upd(32'h0020_1000, 1'b1, 32'h0000_4000);
        look(32'h0000_1000);
        chk("evict_way0", 32'(bus.hit_o), 32'd0);
        look(32'h0010_1000);
        chk("keep_way1", bus.target_o, 32'h0000_3000);
        look(32'h0020_1000);
        chk("third_in_way0", bus.target_o, 32'h0000_4000);
        tick();
        upd(32'h0030_1000, 1'b1, 32'h0000_5000);
        look(32'h0010_1000);
        chk("evict_way1", 32'(bus.hit_o), 32'd0);
        look(32'h0030_1000);
        chk("fourth_target", bus.target_o, 32'h0000_5000);
        look(32'h0020_1000);
        chk("third_kept", 32'(bus.hit_o), 32'd1);

        // Same-cycle update and lookup
        tick();
        bus.pc_f_i          = 32'h0040_2004;
        bus.update_en_i     = 1'b1;
        bus.update_pc_i     = 32'h0040_2004;
        bus.update_taken_i  = 1'b1;
        bus.update_target_i = 32'h0000_8000;
        #1;
        chk("same_cycle_miss", 32'(bus.hit_o), 32'd0);
        tick();
        bus.update_en_i = 1'b0;
        $display("[TB] update pc=%h taken=1 target=%h (same-cycle lookup)", 32'h0040_2004, 32'h0000_8000);
        chk("next_cycle_hit",    32'(bus.hit_o), 32'd1);
        chk("next_cycle_target", bus.target_o,   32'h0000_8000);

        // Retarget on hit; not-taken miss never allocates
        upd(32'h0030_1000, 1'b1, 32'h0000_6000);
        look(32'h0030_1000);
        chk("retarget", bus.target_o, 32'h0000_6000);
        upd(32'h0060_3008, 1'b0, 32'h0000_9000);
        look(32'h0060_3008);
        chk("nt_no_alloc", 32'(bus.hit_o), 32'd0);

        // Flush from RUN with a concurrent update
        bus.flush_i         = 1'b1;
        bus.update_en_i     = 1'b1;
        bus.update_pc_i     = 32'h0050_3000;
        bus.update_taken_i  = 1'b1;
        bus.update_target_i = 32'h0000_A000;
        tick();
        bus.flush_i     = 1'b0;
        bus.update_en_i = 1'b0;
        $display("[TB] update pc=%h taken=1 target=%h with flush", 32'h0050_3000, 32'h0000_A000);
        chk("flush_ready_drop", 32'(bus.ready_o), 32'd0);
        repeat (63) @(posedge clk);
        #1;
        chk("flush_ready_63", 32'(bus.ready_o), 32'd0);
        tick();
        chk("flush_ready_64", 32'(bus.ready_o), 32'd1);
        look(32'h0030_1000);
        chk("flush_cleared_a", 32'(bus.hit_o), 32'd0);
        look(32'h0040_2004);
        chk("flush_cleared_b", 32'(bus.hit_o), 32'd0);
        look(32'h0050_3000);
        chk("flush_cycle_update_cleared", 32'(bus.hit_o), 32'd0);

        // Flush during INIT restarts the sweep
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        chk("reflush_ready_63", 32'(bus.ready_o), 32'd0);
        tick();
        chk("reflush_ready_64", 32'(bus.ready_o), 32'd1);

        // Reset mid-sweep restarts from set 0
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(bus.ready_o), 32'd0);
        tick();
        rst = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        chk("rst_mid_ready_63", 32'(bus.ready_o), 32'd0);
        tick();
        chk("rst_mid_ready_64", 32'(bus.ready_o), 32'd1);

        // Direction behaviour
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        look(32'h0000_1000);
        chk("dir_hit",    32'(bus.hit_o), 32'd1);
        chk("dir_target", bus.target_o,   32'h0000_2000);
`ifdef BTB_ASSOC_CTR_EN
        chk("ctr0_taken", 32'(bus.taken_o), 32'd0);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        look(32'h0000_1000);
        chk("ctr1_taken", 32'(bus.taken_o), 32'd0);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        look(32'h0000_1000);
        chk("ctr2_taken", 32'(bus.taken_o), 32'd1);
`else
        chk("nt_ignored_taken", 32'(bus.taken_o), 32'd1);
`endif
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
